// File: rtl/i2c_wr_arbiter_pkg.sv
// i2c_pkg: definitions shared by the I2C write arbiter and the I2C master.
//   state_e          arbiter FSM states
//   I2C_ADDR_W/DATA  bus field widths shared with the master
//   DEF_TIMEOUT_CYC  default watchdog limit in clk cycles
//   tmr_width()      watchdog counter width for a given limit (never 0)
package i2c_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        RESP  = 2'd3
    } state_e;

    localparam int I2C_ADDR_W      = 7;
    localparam int I2C_DATA_W      = 8;
    localparam int DEF_TIMEOUT_CYC = 65535;

    // A disabled watchdog (limit 0) still needs a 1-bit counter to stay legal.
    function automatic int tmr_width(input int tmo);
        return (tmo < 1) ? 1 : $clog2(tmo + 1);
    endfunction

endpackage

// File: rtl/i2c_wr_arbiter_rr.sv
// rr_arbiter: combinational rotating-priority search.
//   req    [N]     request lines
//   ptr    [ID_W]  index with the highest priority this round
//   en             search enable; when low nothing is granted
//   gnt    [N]     one-hot grant
//   gnt_id [ID_W]  index of the granted line
//   any            a grant was made
module rr_arbiter #(
    parameter int N    = 4,
    parameter int ID_W = 2
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic            en,
    output logic [N-1:0]    gnt,
    output logic [ID_W-1:0] gnt_id,
    output logic            any
);

    always_comb begin
        logic [ID_W-1:0] idx;
        gnt    = '0;
        gnt_id = '0;
        any    = 1'b0;
        idx    = '0;
        if (en) begin
            for (int k = 0; k < N; k++) begin
                idx = ID_W'((int'(ptr) + k) % N);
                if (!any && req[idx]) begin
                    any      = 1'b1;
                    gnt[idx] = 1'b1;
                    gnt_id   = idx;
                end
            end
        end
    end

endmodule

// File: rtl/i2c_wr_arbiter.sv
// i2c_wr_arbiter: shares one I2C write master between NUM_REQ requesters.
//   clk, rst                 clock, async active-high reset
//   req_valid/req_ready      per-requester handshake (ready is a 1-cycle pulse)
//   req_addr/req_data        packed 7-bit address / 8-bit data per requester
//   rsp_done/rsp_err         one-hot completion pulse, err = watchdog timeout
//   m_start/m_addr/m_data    to the master; m_done from the master
//   busy, grant_id           status
//
// state | meaning
// IDLE  | wait for a request while m_done is low, arbitrate, latch it
// ISSUE | m_start high, watchdog running
// DRAIN | m_start low, wait for the master to release done
// RESP  | one-cycle rsp_done/rsp_err to the owner
module i2c_wr_arbiter
    import i2c_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int ID_W        = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*I2C_ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*I2C_DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]            rsp_done,
    output logic                          rsp_err,
    output logic                          m_start,
    output logic [I2C_ADDR_W-1:0]         m_addr,
    output logic [I2C_DATA_W-1:0]         m_data,
    input  logic                          m_done,
    output logic                          busy,
    output logic [ID_W-1:0]               grant_id
);

    localparam int              TMR_W    = tmr_width(TIMEOUT_CYC);
    localparam bit              WDOG_EN  = (TIMEOUT_CYC != 0);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(WDOG_EN ? TIMEOUT_CYC - 1 : 0);
    localparam logic [TMR_W-1:0] TMR_MAX  = '1;
    localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

    state_e                  state_q, state_d;
    logic [NUM_REQ-1:0]      req_ready_q, req_ready_d;
    logic [I2C_ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [I2C_DATA_W-1:0]   m_data_q, m_data_d;
    logic [ID_W-1:0]         grant_q, grant_d;
    logic [ID_W-1:0]         rr_ptr_q, rr_ptr_d;
    logic [TMR_W-1:0]        timer_q, timer_d;
    logic                    err_q, err_d;

    logic                    arb_en;
    logic [NUM_REQ-1:0]      arb_gnt;
    logic [ID_W-1:0]         arb_id;
    logic                    arb_any;

    // A done still high from the previous transfer blocks arbitration so it
    // can never be mistaken for completion of the next one.
    assign arb_en = (state_q == IDLE) && !m_done;

    rr_arbiter #(
        .N    (NUM_REQ),
        .ID_W (ID_W)
    ) u_rr (
        .req    (req_valid),
        .ptr    (rr_ptr_q),
        .en     (arb_en),
        .gnt    (arb_gnt),
        .gnt_id (arb_id),
        .any    (arb_any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= '0;
            m_addr_q    <= '0;
            m_data_q    <= '0;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            timer_q     <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            m_addr_q    <= m_addr_d;
            m_data_q    <= m_data_d;
            grant_q     <= grant_d;
            rr_ptr_q    <= rr_ptr_d;
            timer_q     <= timer_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = '0;
        m_addr_d    = m_addr_q;
        m_data_d    = m_data_q;
        grant_d     = grant_q;
        rr_ptr_d    = rr_ptr_q;
        timer_d     = timer_q;
        err_d       = err_q;

        unique case (state_q)
            IDLE: begin
                if (arb_any) begin
                    req_ready_d = arb_gnt;
                    m_addr_d    = req_addr[int'(arb_id)*I2C_ADDR_W +: I2C_ADDR_W];
                    m_data_d    = req_data[int'(arb_id)*I2C_DATA_W +: I2C_DATA_W];
                    grant_d     = arb_id;
                    rr_ptr_d    = (arb_id == LAST_ID) ? '0 : arb_id + 1'b1;
                    timer_d     = '0;
                    err_d       = 1'b0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // done is checked first so a done arriving on the last
                // watchdog cycle still counts as a clean completion
                if (m_done) begin
                    err_d   = 1'b0;
                    state_d = DRAIN;
                end else if (WDOG_EN && timer_q == TMR_LAST) begin
                    err_d   = 1'b1;
                    state_d = DRAIN;
                end else if (timer_q != TMR_MAX) begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DRAIN: begin
                if (!m_done) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs decode straight from registers so an async reset clears them
    // without waiting for a clock edge.
    always_comb begin
        rsp_done = '0;
        if (state_q == RESP) begin
            rsp_done[grant_q] = 1'b1;
        end
    end

    assign rsp_err   = (state_q == RESP) && err_q;
    assign m_start   = (state_q == ISSUE);
    assign busy      = (state_q != IDLE);
    assign req_ready = req_ready_q;
    assign m_addr    = m_addr_q;
    assign m_data    = m_data_q;
    assign grant_id  = grant_q;

endmodule

// File: tb/tb_i2c_wr_arbiter.sv
module tb_i2c_wr_arbiter;

    localparam int N   = 4;
    localparam int TMO = 1000;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req_valid = '0;
    logic [N-1:0]    req_ready;
    logic [N*7-1:0]  req_addr = '0;
    logic [N*8-1:0]  req_data = '0;
    logic [N-1:0]    rsp_done;
    logic            rsp_err;
    logic            m_start;
    logic [6:0]      m_addr;
    logic [7:0]      m_data;
    logic            m_done = 1'b0;
    logic            busy;
    logic [1:0]      grant_id;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    i2c_wr_arbiter #(
        .NUM_REQ     (N),
        .TIMEOUT_CYC (TMO),
        .ID_W        (2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .rsp_done  (rsp_done),
        .rsp_err   (rsp_err),
        .m_start   (m_start),
        .m_addr    (m_addr),
        .m_data    (m_data),
        .m_done    (m_done),
        .busy      (busy),
        .grant_id  (grant_id)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    // ---------------- transaction-level reference model ----------------
    function automatic int pick(input int ptr, input logic [N-1:0] v);
        int r = -1;
        for (int k = 0; k < N; k++)
            if (r < 0 && v[(ptr + k) % N]) r = (ptr + k) % N;
        return r;
    endfunction

    bit   md_busy, md_start, md_wait, md_resp, md_err;
    int   md_owner, md_ptr, md_ready, md_hi, nxt;
    logic [6:0] md_addr;
    logic [7:0] md_data;

    always_comb nxt = pick(md_ptr, req_valid);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            md_busy <= 0; md_start <= 0; md_wait <= 0; md_resp <= 0; md_err <= 0;
            md_owner <= 0; md_ptr <= 0; md_ready <= -1; md_hi <= 0;
            md_addr <= '0; md_data <= '0;
        end else begin
            md_ready <= -1;
            if (md_resp) begin
                md_resp <= 0;
                md_busy <= 0;
            end else if (!md_busy) begin
                if (!m_done && nxt >= 0) begin
                    md_ready <= nxt;
                    md_owner <= nxt;
                    md_ptr   <= (nxt + 1) % N;
                    md_addr  <= req_addr[7*nxt +: 7];
                    md_data  <= req_data[8*nxt +: 8];
                    md_busy  <= 1;
                    md_start <= 1;
                    md_hi    <= 0;
                end
            end else if (md_start) begin
                // md_hi+1 = number of cycles start has been high so far
                md_hi <= md_hi + 1;
                if (m_done) begin
                    md_start <= 0; md_err <= 0; md_wait <= 1;
                end else if (md_hi + 1 == TMO) begin
                    md_start <= 0; md_err <= 1; md_wait <= 1;
                end
            end else if (md_wait) begin
                if (!m_done) begin
                    md_wait <= 0;
                    md_resp <= 1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("req_ready", 32'(req_ready), (md_ready < 0) ? 32'd0 : (32'd1 << md_ready));
            chk("rsp_done",  32'(rsp_done),  md_resp ? (32'd1 << md_owner) : 32'd0);
            chk("rsp_err",   32'(rsp_err),   32'(md_resp & md_err));
            chk("m_start",   32'(m_start),   32'(md_start));
            chk("busy",      32'(busy),      32'(md_busy));
            chk("m_addr",    32'(m_addr),    32'(md_addr));
            chk("m_data",    32'(m_data),    32'(md_data));
            chk("grant_id",  32'(grant_id),  32'(md_owner));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input int n);
        repeat (n) begin @(posedge clk); #2; end
    endtask

    // sel: 0 m_start high, 1 any ready, 2 any rsp_done
    task automatic wait_for(input string nm, input int sel, input int bound);
        int n = 0;
        bit seen = 0;
        while (!seen && n < bound) begin
            @(negedge clk);
            n++;
            case (sel)
                0:       seen = m_start;
                1:       seen = |req_ready;
                default: seen = |rsp_done;
            endcase
        end
        chk(nm, 32'(seen), 32'd1);
    endtask

    task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] d);
        req_addr[7*i +: 7] = a;
        req_data[8*i +: 8] = d;
    endtask

    // finish a transfer already in ISSUE with a short done pulse
    task automatic finish_xfer(input string nm);
        cyc(4); m_done = 1'b1;
        cyc(2); m_done = 1'b0;
        wait_for(nm, 2, 20);
        cyc(1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "bench timeout");
    end

    initial begin
        int order [5];
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int cnt;
        int hi;

        // reset values
        @(negedge clk);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_start", 32'(m_start), 0);
        chk("rst_ready", 32'(req_ready), 0);
        chk("rst_grant", 32'(grant_id), 0);
        chk("rst_addr", 32'(m_addr), 0);
        cyc(2); rst = 1'b0;
        cyc(2);

        // 1: single request
        set_req(2, 7'h50, 8'hA5);
        req_valid = 4'b0100;
        @(negedge clk); chk("t1_ready_early", 32'(req_ready), 0);
        @(negedge clk);
        chk("t1_ready", 32'(req_ready), 32'b0100);
        chk("t1_addr", 32'(m_addr), 32'h50);
        chk("t1_data", 32'(m_data), 32'hA5);
        chk("t1_grant", 32'(grant_id), 2);
        cyc(1); req_valid = '0;
        cyc(299); m_done = 1'b1;
        cyc(10);  m_done = 1'b0;
        wait_for("t1_rsp_wait", 2, 50);
        chk("t1_rsp", 32'(rsp_done), 32'b0100);
        chk("t1_err", 32'(rsp_err), 0);
        cyc(1);

        // 2: round robin from a fresh pointer
        rst = 1'b1; cyc(2); rst = 1'b0; cyc(1);
        for (int i = 0; i < N; i++) set_req(i, 7'(8'h10 + i), 8'(8'h20 + i));
        req_valid = 4'hF;
        for (int t = 0; t < 5; t++) begin
            wait_for("t2_ready_wait", 1, 20);
            chk("t2_onehot", 32'($onehot(req_ready)), 1);
            order[t] = -1;
            for (int i = 0; i < N; i++) if (req_ready[i]) order[t] = i;
            cyc(4); m_done = 1'b1;
            cyc(2); m_done = 1'b0;
            wait_for("t2_rsp_wait", 2, 20);
            cyc(1);
        end
        req_valid = '0;
        for (int t = 0; t < 5; t++) chk("t2_order", 32'(order[t]), 32'(exp_order[t]));

        // 3: stale done blocks arbitration
        req_valid = 4'b0001;
        wait_for("t3_ready0", 1, 10);
        cyc(1); req_valid = '0;
        cyc(4); m_done = 1'b1;
        cyc(2); m_done = 1'b0;
        wait_for("t3_rsp0", 2, 20);
        cyc(1);
        m_done = 1'b1; req_valid = 4'b0010;
        cnt = 0;
        repeat (200) begin @(negedge clk); if (|req_ready) cnt++; end
        chk("t3_no_ready", 32'(cnt), 0);
        @(posedge clk); #2; m_done = 1'b0;
        @(negedge clk); chk("t3_ready_early", 32'(req_ready), 0);
        @(negedge clk); chk("t3_ready", 32'(req_ready), 32'b0010);
        cyc(1); req_valid = '0;
        finish_xfer("t3_rsp1");

        // 4: timeout, then a late done
        req_valid = 4'b1000;
        wait_for("t4_start", 0, 10);
        cyc(1); req_valid = '0;
        hi = 1;
        for (int n = 0; n < 1100; n++) begin
            @(negedge clk);
            if (m_start) hi++;
            else break;
        end
        chk("t4_start_cycles", 32'(hi), 1000);
        wait_for("t4_rsp_wait", 2, 10);
        chk("t4_rsp", 32'(rsp_done), 32'b1000);
        chk("t4_err", 32'(rsp_err), 1);
        cyc(1); m_done = 1'b1;
        cyc(5); m_done = 1'b0;
        cnt = 0;
        repeat (30) begin @(negedge clk); if (|rsp_done) cnt++; end
        chk("t4_no_extra", 32'(cnt), 0);

        // 5: done on the last watchdog cycle wins
        cyc(1);
        req_valid = 4'b0001;
        wait_for("t5_start", 0, 10);
        cyc(1); req_valid = '0;
        cyc(998); m_done = 1'b1;
        cyc(3);   m_done = 1'b0;
        wait_for("t5_rsp_wait", 2, 20);
        chk("t5_rsp", 32'(rsp_done), 32'b0001);
        chk("t5_err", 32'(rsp_err), 0);
        cyc(1);

        // 6: asynchronous reset during ISSUE
        req_valid = 4'b0010;
        wait_for("t6_ready_wait", 1, 10);
        #1 rst = 1'b1;
        #1;
        chk("t6_start", 32'(m_start), 0);
        chk("t6_busy", 32'(busy), 0);
        chk("t6_ready", 32'(req_ready), 0);
        req_valid = '0;
        cnt = 0;
        repeat (3) begin @(negedge clk); if (|rsp_done) cnt++; end
        chk("t6_no_rsp", 32'(cnt), 0);
        @(posedge clk); #2; rst = 1'b0;
        req_valid = 4'hF;
        wait_for("t6_ready2_wait", 1, 10);
        chk("t6_ptr_zero", 32'(req_ready), 32'b0001);
        cyc(1); req_valid = '0;
        finish_xfer("t6_rsp");
        cyc(5);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/i2c_wr_arbiter.md
Name: i2c_wr_arbiter

Overview:
- Round-robin arbiter that shares one I2C write master (start/addr/data in, done out) between NUM_REQ independent requesters.
- Accepts one write request at a time via a valid/ready handshake and latches its address and data.
- Sequences the master's start/done protocol, then returns a per-requester completion pulse.
- A watchdog aborts transfers whose done never arrives and flags a timeout error.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- TIMEOUT_CYC, 65535, clk cycles allowed from start assertion to done rise; 0 disables the watchdog.
- ID_W, 2, grant index width; must equal clog2(NUM_REQ).

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  NUM_REQ  per-requester request valid; level, held until ready.
- req_ready  out  NUM_REQ  one-hot accept pulse; the handshake completes on the cycle valid&ready.
- req_addr  in  NUM_REQ*7  packed 7-bit slave addresses; requester i uses bits [7i+6:7i].
- req_data  in  NUM_REQ*8  packed write bytes; requester i uses bits [8i+7:8i].
- rsp_done  out  NUM_REQ  one-hot 1-cycle completion pulse to the owning requester.
- rsp_err  out  1  qualifies rsp_done; 1 means the transfer timed out.
- m_start  out  1  to master start; level.
- m_addr  out  7  to master addr; stable while busy.
- m_data  out  8  to master data; stable while busy.
- m_done  in  1  from master done; level, may stay high for many cycles.
- busy  out  1  high from accept until the cycle after rsp_done.
- grant_id  out  ID_W  index of the current or last granted requester.

Behaviour:
- Reset values: req_ready=0, rsp_done=0, rsp_err=0, m_start=0, m_addr=0, m_data=0, busy=0, grant_id=0, rr pointer=0, state=IDLE, timer=0.
- State IDLE:
  - If m_done=1, remain in IDLE. A stale done from a previous transfer must never be taken as completion.
  - Otherwise, if any req_valid is set, pick the first set bit searching circularly from rr_ptr.
  - Assert req_ready[g] for exactly one cycle and latch addr/data of g into m_addr/m_data.
  - Set grant_id=g, set rr_ptr=(g+1) mod NUM_REQ, and go to ISSUE.
  - Latency from valid to ready is 1 cycle, registered.
- State ISSUE:
  - m_start=1 and the timer counts up.
  - If m_done=1, drop m_start and go to DRAIN with err=0.
  - Else if TIMEOUT_CYC!=0 and timer==TIMEOUT_CYC-1, drop m_start and go to DRAIN with err=1.
- State DRAIN:
  - m_start=0; wait until m_done=0, because the master holds done across its own divider period.
  - A done edge seen in DRAIN after a timeout is ignored.
  - On m_done=0, go to RESP.
- State RESP: for one cycle, rsp_done[grant_id]=1 and rsp_err=err. Then go to IDLE; busy falls the next cycle.
- Requester contract:
  - A requester must hold valid until ready.
  - Deasserting req_valid before ready withdraws the request; it is not latched.
  - A new request from the same requester may be presented in the cycle after ready. It competes on the next IDLE.
- Fairness: a requester that is continuously valid is granted within NUM_REQ transfers.
- Simultaneous events:
  - Valid on several lines: only the highest-priority line under the rotating pointer gets ready.
  - m_done rising in the same cycle the timer expires: done wins, err=0.
- Timer:
  - Width is clog2(TIMEOUT_CYC+1).
  - Cleared on entry to ISSUE.
  - Saturates and never wraps.
- Reset mid-operation: all outputs return to reset values immediately. The master sees m_start fall asynchronously. No rsp_done is issued for the aborted transfer.
- Error reporting: there is no sticky error; software observes rsp_err with rsp_done.

Decomposition:
- Shared package i2c_pkg holds:
  - State enum {IDLE, ISSUE, DRAIN, RESP}.
  - I2C_ADDR_W=7 and I2C_DATA_W=8, shared with the master.
  - Default TIMEOUT_CYC.
- Sub-module rr_arbiter:
  - Parameter N; inputs req[N], ptr[ID_W], en.
  - Outputs gnt one-hot, gnt_id, any.
  - Purely combinational priority search, reused by future I2C/SPI schedulers.
- Top level holds the FSM, latches and watchdog.

Test Plan:
1. Single request:
   - req_valid[2]=1, addr=0x50, data=0xA5; master model raises done 300 cycles after start.
   - Expect ready[2] 1 cycle after valid, m_addr=0x50, m_data=0xA5, m_start high until done.
   - Expect rsp_done[2] pulse with rsp_err=0 after done falls, and grant_id=2.
2. Round-robin:
   - All four valid continuously, each with a distinct address.
   - Expect grant order 0,1,2,3,0 and ready one-hot every transfer.
3. Stale done:
   - Hold m_done=1 for 200 cycles after a completion while req_valid[1]=1.
   - Expect no ready[1] until m_done=0, then ready[1] the next cycle.
4. Timeout:
   - TIMEOUT_CYC=1000 and the master never raises done.
   - Expect m_start to drop after exactly 1000 cycles of assertion, then rsp_done[g] with rsp_err=1.
   - A late done pulse afterwards produces no extra rsp_done.
5. Timeout tie:
   - m_done rises on the cycle timer==TIMEOUT_CYC-1.
   - Expect rsp_err=0.
6. Reset mid-ISSUE:
   - Assert rst asynchronously while m_start=1.
   - Expect m_start, busy and req_ready to go 0 without waiting for a clk edge, no rsp_done, and rr_ptr=0 after release.
